// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, types and helpers for the Viterbi traceback path
//
// Purpose: default code/memory dimensions, the trellis predecessor rule,
// modulo-D row-pointer decrement and the traceback FSM encoding.
package viterbi_pkg;

    localparam int K  = 5;              // constraint length
    localparam int M  = K - 1;          // state register width
    localparam int S  = 1 << M;         // number of trellis states
    localparam int D  = 10;             // survivor memory depth (traceback length), D >= 2
    localparam int SW = $clog2(S);      // read-state index width
    localparam int TW = $clog2(D);      // survivor row pointer width
    localparam int FW = $clog2(D + 1);  // fill counter width, must hold the value D

    typedef logic [M-1:0]  state_t;
    typedef logic [TW-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        EMIT
    } tb_state_e;

    // Walking backward, the older state is the current state shifted up
    // with the stored decision bit entering at the LSB.
    function automatic state_t prev_state(state_t s, bit b);
        return {s[M-2:0], b};
    endfunction

    // Row pointer decrement that wraps from 0 to D-1.
    function automatic ptr_t ptr_dec(ptr_t p);
        return (p == '0) ? ptr_t'(D - 1) : p - ptr_t'(1);
    endfunction

endpackage

// File: rtl/traceback_unit.sv
// rtl/traceback_unit.sv - Viterbi traceback: walks survivor rows backward and emits one decoded bit per request
//
// Purpose: on each accepted tb_start, starts at start_state on the newest
// row (wr_ptr-1) and follows D-1 survivor decisions back through the
// memory, one read per clock, then emits the input bit of the oldest row.
// Build option: TB_OVERRUN_CNT_EN adds a saturating overrun event counter.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tb_start      traceback request (ignored and flagged while busy)
//   start_state   best state at the newest step, sampled with tb_start
//   wr_ptr        survivor write pointer (one past newest row), sampled with tb_start
//   rd_state      survivor memory read state (registered)
//   rd_time       survivor memory read row (registered)
//   surv_bit      combinational survivor decision for (rd_state, rd_time)
//   busy          high while tracing
//   out_valid     one-cycle pulse, out_bit valid (suppressed during warm-up)
//   out_bit       decoded bit, held between emissions
//   overrun       one-cycle pulse after a tb_start seen while tracing
//   overrun_cnt   saturating overrun count (TB_OVERRUN_CNT_EN only)
module traceback_unit
    import viterbi_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          tb_start,
    input  logic [M-1:0]  start_state,
    input  logic [TW-1:0] wr_ptr,
    output logic [SW-1:0] rd_state,
    output logic [TW-1:0] rd_time,
    input  logic          surv_bit,
    output logic          busy,
    output logic          out_valid,
    output logic          out_bit,
`ifdef TB_OVERRUN_CNT_EN
    output logic [7:0]    overrun_cnt,
`endif
    output logic          overrun
);

    localparam logic [TW-1:0] STEP_LAST = TW'(D - 2);

    tb_state_e fsm_q, fsm_d;
    state_t    sst_q, sst_d;
    ptr_t      t_q, t_d;
    logic [TW-1:0] step_q, step_d;
    logic [FW-1:0] fill_q, fill_d;
    logic      out_valid_q, out_valid_d;
    logic      out_bit_q, out_bit_d;
    logic      overrun_q, overrun_d;
    logic      accept;
    state_t    trace_state;

    // EMIT accepts a request just like IDLE, so back-to-back traces lose no cycle.
    assign accept      = tb_start && (fsm_q != TRACE);
    assign trace_state = prev_state(sst_q, surv_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            sst_q       <= '0;
            t_q         <= '0;
            step_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            sst_q       <= sst_d;
            t_q         <= t_d;
            step_q      <= step_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (tb_start) fsm_d = TRACE;
            TRACE:   if (step_q == STEP_LAST) fsm_d = EMIT;
            EMIT:    fsm_d = tb_start ? TRACE : IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        sst_d       = sst_q;
        t_d         = t_q;
        step_d      = step_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        overrun_d   = tb_start && (fsm_q == TRACE);

        if (accept) begin
            sst_d  = start_state;
            t_d    = ptr_dec(wr_ptr);
            step_d = '0;
            fill_d = (fill_q == FW'(D)) ? fill_q : fill_q + 1'b1;
        end

        if (fsm_q == TRACE) begin
            sst_d  = trace_state;
            t_d    = ptr_dec(t_q);
            step_d = step_q + 1'b1;
            // Output registers load on the edge into EMIT so they are visible during EMIT.
            if (fsm_d == EMIT) begin
                out_valid_d = (fill_q == FW'(D));
                out_bit_d   = trace_state[M-1];
            end
        end
    end

    assign busy      = (fsm_q == TRACE);
    assign rd_state  = sst_q;
    assign rd_time   = t_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign overrun   = overrun_q;

`ifdef TB_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_traceback_unit.sv
// tb/tb_traceback_unit.sv - directed self-checking bench for traceback_unit
module tb_traceback_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_start;
    logic [3:0] start_state;
    logic [3:0] wr_ptr;
    logic [3:0] rd_state;
    logic [3:0] rd_time;
    logic       surv_bit;
    logic       busy;
    logic       out_valid;
    logic       out_bit;
    logic       overrun;
`ifdef TB_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // 0: all-zero memory, 1: all-ones memory, 2: decision = row parity
    logic [1:0] mem_mode;
    assign surv_bit = (mem_mode == 2'd0) ? 1'b0 :
                      (mem_mode == 2'd1) ? 1'b1 : rd_time[0];

    logic [3:0] rec_s[9];
    logic [3:0] rec_t[9];
    logic [3:0] exp_s[9];
    logic [3:0] exp_t[9];

    always #5 clk = ~clk;

    traceback_unit dut (
        .clk         (clk),
        .rst         (rst),
        .tb_start    (tb_start),
        .start_state (start_state),
        .wr_ptr      (wr_ptr),
        .rd_state    (rd_state),
        .rd_time     (rd_time),
        .surv_bit    (surv_bit),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
`ifdef TB_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; issues one request and walks through TRACE and EMIT.
    task automatic do_trace(input logic [3:0] st, input logic [3:0] wp,
                            input logic ev, input logic eb, input string tag);
        int early;
        early       = 0;
        tb_start    = 1'b1;
        start_state = st;
        wr_ptr      = wp;
        @(negedge clk);
        tb_start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < 9; i++) begin
            rec_s[i] = rd_state;
            rec_t[i] = rd_time;
            if (out_valid) early++;
            @(negedge clk);
        end
        chk({tag, "_early_valid"}, early, 0);
        chk({tag, "_valid"}, out_valid, ev);
        if (ev) chk({tag, "_bit"}, out_bit, eb);
        chk({tag, "_emit_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, out_valid, 0);
    endtask

    task automatic check_seq(input string tag);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_time%0d", tag, i), rec_t[i], exp_t[i]);
            chk($sformatf("%s_state%0d", tag, i), rec_s[i], exp_s[i]);
        end
    endtask

    initial begin
        int nv;
        rst         = 1'b1;
        tb_start    = 1'b0;
        start_state = '0;
        wr_ptr      = '0;
        mem_mode    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_state", rd_state, 0);
        chk("rst_rd_time", rd_time, 0);
`ifdef TB_OVERRUN_CNT_EN
        chk("rst_overrun_cnt", overrun_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Warm-up: nine requests fill the window without producing output.
        for (int r = 0; r < 9; r++) do_trace(4'(r), 4'(r), 1'b0, 1'b0, "warm");

        // Tenth request, all-zero memory.
        exp_t = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        exp_s = '{4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        do_trace(4'd8, 4'd3, 1'b1, 1'b0, "zero");
        check_seq("zero");

        // All-ones memory from state 0 with wr_ptr wrapping from 0.
        mem_mode = 2'd1;
        exp_t = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        exp_s = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        do_trace(4'd0, 4'd0, 1'b1, 1'b1, "ones");
        check_seq("ones");

        // Decision equals row parity: odd rows hold 1.
        mem_mode = 2'd2;
        exp_t = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8, 4'd7, 4'd6};
        exp_s = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd10, 4'd5, 4'd10, 4'd5};
        do_trace(4'd0, 4'd5, 1'b1, 1'b1, "par");
        check_seq("par");

        // Overrun: second request lands in the third TRACE cycle.
        mem_mode    = 2'd1;
        tb_start    = 1'b1;
        start_state = 4'd0;
        wr_ptr      = 4'd0;
        @(negedge clk);
        tb_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tb_start    = 1'b1;
        start_state = 4'd8;
        wr_ptr      = 4'd5;
        @(negedge clk);
        tb_start = 1'b0;
        chk("ovr_pulse", overrun, 1);
        chk("ovr_rd_time", rd_time, 6);
        @(negedge clk);
        chk("ovr_pulse_end", overrun, 0);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) begin
                nv++;
                chk("ovr_bit", out_bit, 1);
            end
            @(negedge clk);
        end
        chk("ovr_valid_count", nv, 1);
`ifdef TB_OVERRUN_CNT_EN
        chk("ovr_cnt", overrun_cnt, 1);
`endif

        // Reset in the fifth TRACE cycle.
        mem_mode    = 2'd0;
        tb_start    = 1'b1;
        start_state = 4'd8;
        wr_ptr      = 4'd3;
        @(negedge clk);
        tb_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
`ifdef TB_OVERRUN_CNT_EN
        chk("mrst_ovr_cnt", overrun_cnt, 0);
`endif
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        chk("mrst_no_valid", nv, 0);
        for (int r = 0; r < 9; r++) do_trace(4'(r), 4'(9 - r), 1'b0, 1'b0, "rewarm");
        do_trace(4'd8, 4'd3, 1'b1, 1'b0, "refill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
